// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for a shared one-bit ALU slice: sweeps a WIDTH-bit operation
// LSB-first, one bit per clock, with a second sweep that materialises the SLT result.
module serial_alu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       aluop,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   output logic             alu_less,
   output logic [2:0]       alu_op,
   input  logic             alu_out,
   input  logic             alu_cout
);

   localparam int                IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0]  IDX_ZERO = IDX_W'(0);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PASS1 = 2'b01,
      PASS2 = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [2:0]        aluop_r;
   logic [IDX_W-1:0]  idx_r;
   logic              cy_r;
   logic              set_r;
   logic [WIDTH-1:0]  result_r;
   logic              zero_r;
   logic              carry_r;
   logic              ovf_r;
   logic              busy_r;
   logic              done_r;

   logic              accept_s;
   logic              last_s;
   logic              arith_s;
   logic              ovf_s;
   logic [WIDTH-1:0]  result_nxt_s;

   assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
   assign last_s   = (idx_r == IDX_LAST);
   assign arith_s  = (aluop_r == OP_ADD) || (aluop_r == OP_SUB) || (aluop_r == OP_SLT);
   // Carry into the MSB differs from carry out of it exactly on signed overflow.
   assign ovf_s    = alu_cin ^ alu_cout;

   // Result image with the current slice bit merged in at position idx.
   always_comb begin
      result_nxt_s        = result_r;
      result_nxt_s[idx_r] = alu_out;
   end

   // Next-state selection for the sweep sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = PASS1;
            else          state_s = IDLE;
         end
         PASS1: begin
            if (last_s) state_s = (aluop_r == OP_SLT) ? PASS2 : DONE;
            else        state_s = PASS1;
         end
         PASS2: begin
            if (last_s) state_s = DONE;
            else        state_s = PASS2;
         end
         DONE: begin
            if (accept_s) state_s = PASS1;
            else          state_s = IDLE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Slice input steering from the latched operands and bit position.
   always_comb begin
      alu_a    = a_r[idx_r];
      alu_b    = b_r[idx_r];
      alu_cin  = (idx_r == IDX_ZERO) ? aluop_r[2] : cy_r;
      alu_less = 1'b0;
      alu_op   = aluop_r;
      case (state_r)
         PASS2: begin
            alu_op   = OP_SLT;
            alu_less = (idx_r == IDX_ZERO) ? set_r : 1'b0;
         end
         PASS1, IDLE, DONE: begin
            alu_op = (aluop_r == OP_SLT) ? OP_SUB : aluop_r;
         end
         default: alu_op = aluop_r;
      endcase
   end

   // Sequencer state, operand latches, bit collection and flag capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         aluop_r  <= 3'b000;
         idx_r    <= IDX_ZERO;
         cy_r     <= 1'b0;
         set_r    <= 1'b0;
         result_r <= {WIDTH{1'b0}};
         zero_r   <= 1'b0;
         carry_r  <= 1'b0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == PASS1) || (state_s == PASS2);
         done_r  <= (state_s == DONE);
         case (state_r)
            IDLE, DONE: begin
               if (accept_s) begin
                  a_r     <= a;
                  b_r     <= b;
                  aluop_r <= aluop;
                  idx_r   <= IDX_ZERO;
               end else begin
                  idx_r   <= idx_r;
               end
            end
            PASS1: begin
               result_r <= result_nxt_s;
               cy_r     <= alu_cout;
               if (last_s) begin
                  idx_r   <= IDX_ZERO;
                  carry_r <= arith_s & alu_cout;
                  ovf_r   <= arith_s & ovf_s;
                  set_r   <= alu_out ^ ovf_s;
                  // SLT's final zero flag comes from the second sweep instead.
                  if (aluop_r != OP_SLT) zero_r <= (result_nxt_s == {WIDTH{1'b0}});
                  else                   zero_r <= zero_r;
               end else begin
                  idx_r <= idx_r + IDX_ONE;
               end
            end
            PASS2: begin
               result_r <= result_nxt_s;
               cy_r     <= alu_cout;
               if (last_s) begin
                  idx_r  <= IDX_ZERO;
                  zero_r <= (result_nxt_s == {WIDTH{1'b0}});
               end else begin
                  idx_r  <= idx_r + IDX_ONE;
               end
            end
            default: idx_r <= IDX_ZERO;
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign result    = result_r;
   assign zero      = zero_r;
   assign carry_out = carry_r;
   assign overflow  = ovf_r;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl: models the one-bit MIPS ALU slice and checks every
// operation against a word-level arithmetic reference.
module tb_serial_alu_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a_in = '0;
   logic [W-1:0]  b_in = '0;
   logic [2:0]    op_in = 3'b000;
   logic          busy, done, zero, carry_out, overflow;
   logic [W-1:0]  result;
   logic          alu_a, alu_b, alu_cin, alu_less, alu_out, alu_cout;
   logic [2:0]    alu_op;
   logic          bb;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a_in), .b(b_in), .aluop(op_in),
      .busy(busy), .done(done), .result(result), .zero(zero),
      .carry_out(carry_out), .overflow(overflow),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_less(alu_less),
      .alu_op(alu_op), .alu_out(alu_out), .alu_cout(alu_cout)
   );

   // One-bit MIPS ALU slice: op[2] inverts B, op[1:0] selects AND/OR/SUM/LESS.
   always_comb begin
      bb       = alu_op[2] ? ~alu_b : alu_b;
      alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
      case (alu_op[1:0])
         2'b00:   alu_out = alu_a & bb;
         2'b01:   alu_out = alu_a | bb;
         2'b10:   alu_out = alu_a ^ bb ^ alu_cin;
         default: alu_out = alu_less;
      endcase
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, output logic [W-1:0] r,
                                 output logic c, output logic v);
      logic [W:0] s;
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0]; c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b110, 3'b111: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[W-1:0]; c = s[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            if (op == 3'b111) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         end
         default: r = '0;
      endcase
   endfunction

   // Called at #1 after an edge with the DUT idle or in its done cycle; returns at
   // #1 after the edge that starts the done cycle (or after the cycle budget).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input int glitch, input string tag);
      logic [W-1:0] er;
      logic ec, ev;
      int lat, k;
      bit got, busy_ok;
      model(a, b, op, er, ec, ev);
      lat = (op == 3'b111) ? 2 * W + 1 : W + 1;
      a_in = a; b_in = b; op_in = op; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 1; got = 1'b0; busy_ok = 1'b1;
      while (k <= 3 * W && !got) begin
         if (done) begin
            got = 1'b1;
         end else begin
            if (!busy) busy_ok = 1'b0;
            if (k == glitch) begin
               start = 1'b1; a_in = ~a; b_in = a; op_in = 3'b001;
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
         end
      end
      start = 1'b0;
      check({tag, " done_cycle"}, k, lat);
      check({tag, " result"}, result, er);
      check({tag, " zero"}, zero, (er == '0));
      check({tag, " carry_out"}, carry_out, ec);
      check({tag, " overflow"}, overflow, ev);
      check({tag, " busy_during"}, busy_ok, 1'b1);
      check({tag, " busy_at_done"}, busy, 1'b0);
   endtask

   logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

   initial begin
      bit no_done;
      logic [W-1:0] held;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst result", result, 32'h0);
      check("rst zero", zero, 1'b0);
      check("rst carry", carry_out, 1'b0);
      check("rst ovf", overflow, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(32'h7FFFFFFF, 32'h00000001, 3'b010, 0, "add_ovf");
      check("add_ovf value", result, 32'h80000000);
      @(posedge clk); #1;
      run_op(32'h00000005, 32'h00000005, 3'b110, 0, "sub_zero");
      check("sub_zero flag", zero, 1'b1);
      run_op(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 0, "and");
      check("and value", result, 32'hF000F000);
      run_op(32'h0F0F0000, 32'h000000F0, 3'b001, 0, "or");
      check("or value", result, 32'h0F0F00F0);
      held = result;
      repeat (3) begin @(posedge clk); #1; end
      check("hold result", result, held);
      check("hold done", done, 1'b0);
      run_op(32'hFFFFFFFF, 32'h00000001, 3'b111, 0, "slt_neg");
      check("slt_neg value", result, 32'h00000001);
      run_op(32'h7FFFFFFF, 32'h80000000, 3'b111, 0, "slt_ovf");
      check("slt_ovf value", result, 32'h00000000);
      run_op(32'h12345678, 32'h11111111, 3'b010, 10, "add_glitch");
      check("add_glitch value", result, 32'h23456789);

      // Reset in the middle of an SLT sweep.
      a_in = 32'h00000003; b_in = 32'h00000009; op_in = 3'b111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort result", result, 32'h0);
      check("abort zero", zero, 1'b0);
      check("abort carry", carry_out, 1'b0);
      check("abort ovf", overflow, 1'b0);
      reset = 1'b0;
      no_done = 1'b1;
      repeat (2 * W + 4) begin
         @(posedge clk); #1;
         if (done || busy) no_done = 1'b0;
      end
      check("abort quiet", no_done, 1'b1);
      run_op(32'h00000001, 32'h00000001, 3'b010, 0, "add_after_rst");
      check("add_after_rst value", result, 32'h00000002);

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb;
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
         end
         run_op(ra, rb, legal[$urandom_range(0, 4)], 0, "rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
